// File: rtl/writeback_unit.sv
// writeback_unit: MEM/WB pipeline register and writeback stage.
// Captures the instruction leaving MEM, selects and size-extends the result,
// drives the register file write port, supplies write-to-read bypass data to
// decode and counts retired instructions.
// Optional feature macro: WB_BYPASS_EN (when undefined, bp_dataN = rf_dataN).

module writeback_unit #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_to_reg,
  input  logic             mem_link,
  input  logic [1:0]       mem_size,
  input  logic             mem_signed,
  input  logic [4:0]       mem_rd,
  input  logic [63:0]      mem_alu_result,
  input  logic [63:0]      mem_load_data,
  input  logic [63:0]      mem_pc_plus4,
  output logic [63:0]      WriteData,
  output logic [4:0]       WriteRegister,
  output logic             RegWrite,
  input  logic [4:0]       rd_addr1,
  input  logic [4:0]       rd_addr2,
  input  logic [63:0]      rf_data1,
  input  logic [63:0]      rf_data2,
  output logic [63:0]      bp_data1,
  output logic [63:0]      bp_data2,
  output logic [CNT_W-1:0] retired
);

  localparam logic [4:0] LINK_REG = 5'd30;
  localparam logic [4:0] ZERO_REG = 5'd31;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // MEM/WB pipeline register contents
  logic             r_valid;
  logic             r_reg_write;
  logic             r_to_reg;
  logic             r_link;
  logic [1:0]       r_size;
  logic             r_signed;
  logic [4:0]       r_rd;
  logic [63:0]      r_alu_result;
  logic [63:0]      r_load_data;
  logic [63:0]      r_pc_plus4;
  logic [CNT_W-1:0] r_retired;

  logic        w_fire;
  logic [63:0] w_load_ext;
  logic [63:0] w_result;
  logic [4:0]  w_dest;
  logic        w_reg_write;

  // Pipeline register: stall holds everything, flush injects a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid      <= 1'b0;
      r_reg_write  <= 1'b0;
      r_to_reg     <= 1'b0;
      r_link       <= 1'b0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_rd         <= 5'd0;
      r_alu_result <= 64'd0;
      r_load_data  <= 64'd0;
      r_pc_plus4   <= 64'd0;
    end else if (!stall) begin
      if (flush) begin
        r_valid <= 1'b0;
      end else begin
        r_valid      <= mem_valid;
        r_reg_write  <= mem_reg_write;
        r_to_reg     <= mem_to_reg;
        r_link       <= mem_link;
        r_size       <= mem_size;
        r_signed     <= mem_signed;
        r_rd         <= mem_rd;
        r_alu_result <= mem_alu_result;
        r_load_data  <= mem_load_data;
        r_pc_plus4   <= mem_pc_plus4;
      end
    end
  end

  // An instruction leaves the pipeline only in a cycle where it is not held
  assign w_fire = r_valid & ~stall;

  // Retired-instruction counter counts every fired instruction, wrapping freely
  always_ff @(posedge clk) begin
    if (reset) begin
      r_retired <= '0;
    end else if (w_fire) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  // Size-extend the right-aligned load data to 64 bits
  always_comb begin
    w_load_ext = r_load_data;
    case (r_size)
      SIZE_BYTE: w_load_ext = {{56{r_signed & r_load_data[7]}},  r_load_data[7:0]};
      SIZE_HALF: w_load_ext = {{48{r_signed & r_load_data[15]}}, r_load_data[15:0]};
      SIZE_WORD: w_load_ext = {{32{r_signed & r_load_data[31]}}, r_load_data[31:0]};
      default:   w_load_ext = r_load_data;
    endcase
  end

  // Result select: link beats load, load beats ALU; link also forces X30
  always_comb begin
    w_result = r_alu_result;
    w_dest   = r_rd;
    if (r_link) begin
      w_result = r_pc_plus4;
      w_dest   = LINK_REG;
    end else if (r_to_reg) begin
      w_result = w_load_ext;
    end
  end

  // Writes to X31 are dropped so the zero register never changes
  assign w_reg_write = w_fire & (r_reg_write | r_link) & (w_dest != ZERO_REG);

  assign WriteData     = w_result;
  assign WriteRegister = w_dest;
  assign RegWrite      = w_reg_write;
  assign retired       = r_retired;

`ifdef WB_BYPASS_EN
  // Same-cycle bypass: forward the value being written if decode reads it
  always_comb begin
    bp_data1 = rf_data1;
    bp_data2 = rf_data2;
    if (w_reg_write && (w_dest == rd_addr1)) begin
      bp_data1 = w_result;
    end
    if (w_reg_write && (w_dest == rd_addr2)) begin
      bp_data2 = w_result;
    end
  end
`else
  // No bypass: the hazard unit stalls decode on writeback RAW hazards
  always_comb begin
    bp_data1 = rf_data1;
    bp_data2 = rf_data2;
  end
`endif

endmodule
